// File: rtl/bullcow_pkg.sv
// Shared types for the Bulls-and-Cows game controller.
//   state_t : game phase, exported on the phase output (3 bits)
//   WIN_*   : winner output encoding
package bullcow_pkg;

    typedef enum logic [2:0] {
        J1_SETUP = 3'd0,
        J2_SETUP = 3'd1,
        J1_GUESS = 3'd2,
        J2_GUESS = 3'd3,
        END_GAME = 3'd7
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_J1   = 2'd1;
    localparam logic [1:0] WIN_J2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

endpackage

// File: rtl/bullcow_scorer.sv
// Combinational guess scorer.
//   guess  in  : DIGITS*DIGIT_W entry, digit i at [i*DIGIT_W +: DIGIT_W]
//   secret in  : stored secret, same layout
//   valid  out : guess digits pairwise distinct and all <= DIGIT_MAX
//   bulls  out : digits matching in value and position
//   cows   out : digits present in the secret at a different position
module bullcow_scorer #(
    parameter int DIGITS    = 4,
    parameter int DIGIT_W   = 4,
    parameter int DIGIT_MAX = 9,
    localparam int CNT_W    = $clog2(DIGITS + 1)
) (
    input  logic [DIGITS*DIGIT_W-1:0] guess,
    input  logic [DIGITS*DIGIT_W-1:0] secret,
    output logic                      valid,
    output logic [CNT_W-1:0]          bulls,
    output logic [CNT_W-1:0]          cows
);

    always_comb begin
        valid = 1'b1;
        bulls = '0;
        cows  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (guess[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(DIGIT_MAX))
                valid = 1'b0;
            for (int j = i + 1; j < DIGITS; j++) begin
                if (guess[i*DIGIT_W +: DIGIT_W] == guess[j*DIGIT_W +: DIGIT_W])
                    valid = 1'b0;
            end
            // Secrets hold distinct digits, so each guess digit matches at
            // most one secret position: no double counting of cows.
            for (int j = 0; j < DIGITS; j++) begin
                if (guess[i*DIGIT_W +: DIGIT_W] == secret[j*DIGIT_W +: DIGIT_W]) begin
                    if (i == j) bulls = bulls + CNT_W'(1);
                    else        cows  = cows + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bullcow_game_param.sv
// Two-player Bulls-and-Cows game controller.
//   clock, reset(active-low, sync)  ; enter pulse + digits_in entry
//   phase        : current state_t
//   bulls/cows   : score of last accepted guess, result_valid pulses on update
//   entry_err    : pulse when an entry was rejected as invalid
//   game_over    : high in END_GAME, winner valid then (WIN_* encoding)
//   points_j1/j2 : saturating win counters, survive across games
//   round_cnt    : completed rounds (J1 + J2 guess) in this game
module bullcow_game_param
    import bullcow_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DIGIT_W    = 4,
    parameter int DIGIT_MAX  = 9,
    parameter int MAX_ROUNDS = 10,
    parameter int SCORE_W    = 8,
    localparam int CNT_W     = $clog2(DIGITS + 1),
    localparam int RND_W     = (MAX_ROUNDS > 0) ? $clog2(MAX_ROUNDS + 1) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enter,
    input  logic [DIGITS*DIGIT_W-1:0] digits_in,
    output logic [2:0]                phase,
    output logic [CNT_W-1:0]          bulls,
    output logic [CNT_W-1:0]          cows,
    output logic                      result_valid,
    output logic                      entry_err,
    output logic                      game_over,
    output logic [1:0]                winner,
    output logic [SCORE_W-1:0]        points_j1,
    output logic [SCORE_W-1:0]        points_j2,
    output logic [RND_W-1:0]          round_cnt
);

    localparam int DW = DIGITS * DIGIT_W;

    state_t             state_q, state_d;
    logic [DW-1:0]      sec1_q, sec1_d, sec2_q, sec2_d;
    logic [CNT_W-1:0]   bulls_q, bulls_d, cows_q, cows_d;
    logic               rv_q, rv_d, err_q, err_d;
    logic [1:0]         winner_q, winner_d;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [RND_W-1:0]   rnd_q, rnd_d, rnd_inc;

    logic               sc_valid;
    logic [CNT_W-1:0]   sc_bulls, sc_cows;
    logic [DW-1:0]      sc_secret;

    // J2 guesses against J1's secret; every other phase scores against J2's.
    assign sc_secret = (state_q == J2_GUESS) ? sec1_q : sec2_q;

    bullcow_scorer #(
        .DIGITS    (DIGITS),
        .DIGIT_W   (DIGIT_W),
        .DIGIT_MAX (DIGIT_MAX)
    ) u_scorer (
        .guess  (digits_in),
        .secret (sc_secret),
        .valid  (sc_valid),
        .bulls  (sc_bulls),
        .cows   (sc_cows)
    );

    always_comb begin
        state_d  = state_q;
        sec1_d   = sec1_q;
        sec2_d   = sec2_q;
        bulls_d  = bulls_q;
        cows_d   = cows_q;
        rv_d     = 1'b0;
        err_d    = 1'b0;
        winner_d = winner_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        rnd_d    = rnd_q;
        rnd_inc  = rnd_q + RND_W'(1);

        case (state_q)
            J1_SETUP: if (enter) begin
                if (!sc_valid) err_d = 1'b1;
                else begin
                    sec1_d  = digits_in;
                    state_d = J2_SETUP;
                end
            end
            J2_SETUP: if (enter) begin
                if (!sc_valid) err_d = 1'b1;
                else begin
                    sec2_d  = digits_in;
                    rnd_d   = '0;
                    state_d = J1_GUESS;
                end
            end
            J1_GUESS: if (enter) begin
                if (!sc_valid) err_d = 1'b1;
                else begin
                    bulls_d = sc_bulls;
                    cows_d  = sc_cows;
                    rv_d    = 1'b1;
                    if (sc_bulls == CNT_W'(DIGITS)) begin
                        state_d  = END_GAME;
                        winner_d = WIN_J1;
                        if (p1_q != '1) p1_d = p1_q + SCORE_W'(1);
                    end else begin
                        state_d = J2_GUESS;
                    end
                end
            end
            J2_GUESS: if (enter) begin
                if (!sc_valid) err_d = 1'b1;
                else begin
                    bulls_d = sc_bulls;
                    cows_d  = sc_cows;
                    rv_d    = 1'b1;
                    if (sc_bulls == CNT_W'(DIGITS)) begin
                        state_d  = END_GAME;
                        winner_d = WIN_J2;
                        if (p2_q != '1) p2_d = p2_q + SCORE_W'(1);
                    end else begin
                        rnd_d = rnd_inc;
                        // MAX_ROUNDS == 0 means the game only ends on a hit.
                        if ((MAX_ROUNDS != 0) && (rnd_inc == RND_W'(MAX_ROUNDS))) begin
                            state_d  = END_GAME;
                            winner_d = WIN_DRAW;
                        end else begin
                            state_d = J1_GUESS;
                        end
                    end
                end
            end
            END_GAME: if (enter) begin
                state_d  = J1_SETUP;
                winner_d = WIN_NONE;
                bulls_d  = '0;
                cows_d   = '0;
                rnd_d    = '0;
            end
            default: state_d = J1_SETUP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= J1_SETUP;
            sec1_q   <= '0;
            sec2_q   <= '0;
            bulls_q  <= '0;
            cows_q   <= '0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
            winner_q <= WIN_NONE;
            p1_q     <= '0;
            p2_q     <= '0;
            rnd_q    <= '0;
        end else begin
            state_q  <= state_d;
            sec1_q   <= sec1_d;
            sec2_q   <= sec2_d;
            bulls_q  <= bulls_d;
            cows_q   <= cows_d;
            rv_q     <= rv_d;
            err_q    <= err_d;
            winner_q <= winner_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            rnd_q    <= rnd_d;
        end
    end

    assign phase        = state_q;
    assign bulls        = bulls_q;
    assign cows         = cows_q;
    assign result_valid = rv_q;
    assign entry_err    = err_q;
    assign game_over    = (state_q == END_GAME);
    assign winner       = winner_q;
    assign points_j1    = p1_q;
    assign points_j2    = p2_q;
    assign round_cnt    = rnd_q;

endmodule

// File: tb/tb_bullcow_game_param.sv
module tb_bullcow_game_param;
    import bullcow_pkg::*;

    logic clock, reset;

    // 4-digit instance: short draw limit and narrow score to hit corners fast.
    logic        enter;
    logic [15:0] din;
    logic [2:0]  phase, bulls, cows;
    logic        rv, err, go;
    logic [1:0]  win, p1, p2, rnd;

    bullcow_game_param #(.DIGITS(4), .DIGIT_W(4), .DIGIT_MAX(9), .MAX_ROUNDS(2), .SCORE_W(2)) dut (
        .clock(clock), .reset(reset), .enter(enter), .digits_in(din),
        .phase(phase), .bulls(bulls), .cows(cows), .result_valid(rv),
        .entry_err(err), .game_over(go), .winner(win),
        .points_j1(p1), .points_j2(p2), .round_cnt(rnd)
    );

    // 6-digit instance, default limits.
    logic        enter6;
    logic [23:0] din6;
    logic [2:0]  phase6, bulls6, cows6;
    logic        rv6, err6, go6;
    logic [1:0]  win6;
    logic [7:0]  p1_6, p2_6;
    logic [3:0]  rnd6;

    bullcow_game_param #(.DIGITS(6), .DIGIT_W(4), .DIGIT_MAX(9), .MAX_ROUNDS(10), .SCORE_W(8)) dut6 (
        .clock(clock), .reset(reset), .enter(enter6), .digits_in(din6),
        .phase(phase6), .bulls(bulls6), .cows(cows6), .result_valid(rv6),
        .entry_err(err6), .game_over(go6), .winner(win6),
        .points_j1(p1_6), .points_j2(p2_6), .round_cnt(rnd6)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [15:0] din;
        logic [2:0]  ph;
        logic [2:0]  b, c;
        logic        rv, err, go;
        logic [1:0]  win, p1, p2, rnd;
    } vec_t;

    vec_t vt[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    function automatic vec_t mk(logic r, logic e, logic [15:0] d, state_t ph,
                                int b, int c, logic v, logic er, logic g,
                                logic [1:0] w, int a1, int a2, int rn);
        vec_t x;
        x.rst_n = r; x.en = e; x.din = d; x.ph = ph;
        x.b = 3'(b); x.c = 3'(c); x.rv = v; x.err = er; x.go = g;
        x.win = w; x.p1 = 2'(a1); x.p2 = 2'(a2); x.rnd = 2'(rn);
        return x;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else n_pass++;
    endtask

    // Drive at a negedge, sample at the next negedge (after one active edge).
    task automatic apply(string tag, vec_t v);
        reset = v.rst_n; enter = v.en; din = v.din;
        @(negedge clock);
        chk({tag, ".phase"},  32'(phase), 32'(v.ph));
        chk({tag, ".bulls"},  32'(bulls), 32'(v.b));
        chk({tag, ".cows"},   32'(cows),  32'(v.c));
        chk({tag, ".rv"},     32'(rv),    32'(v.rv));
        chk({tag, ".err"},    32'(err),   32'(v.err));
        chk({tag, ".go"},     32'(go),    32'(v.go));
        chk({tag, ".winner"}, 32'(win),   32'(v.win));
        chk({tag, ".p1"},     32'(p1),    32'(v.p1));
        chk({tag, ".p2"},     32'(p2),    32'(v.p2));
        chk({tag, ".round"},  32'(rnd),   32'(v.rnd));
    endtask

    task automatic apply6(string tag, logic [23:0] d, state_t ph, int b, int c,
                          logic v, logic er, int rn);
        enter6 = 1'b1; din6 = d;
        @(negedge clock);
        chk({tag, ".phase"}, 32'(phase6), 32'(ph));
        chk({tag, ".bulls"}, 32'(bulls6), 32'(b));
        chk({tag, ".cows"},  32'(cows6),  32'(c));
        chk({tag, ".rv"},    32'(rv6),    32'(v));
        chk({tag, ".err"},   32'(err6),   32'(er));
        chk({tag, ".round"}, 32'(rnd6),   32'(rn));
    endtask

    initial begin
        reset = 1'b0; enter = 1'b0; din = '0; enter6 = 1'b0; din6 = '0;

        //             rst en  din       phase     b  c  rv err go win       p1 p2 rnd
        vt.push_back(mk(0, 0, 16'h0000, J1_SETUP, 0, 0, 0, 0, 0, WIN_NONE, 0, 0, 0));
        vt.push_back(mk(1, 1, 16'h1123, J1_SETUP, 0, 0, 0, 1, 0, WIN_NONE, 0, 0, 0));
        vt.push_back(mk(1, 1, 16'h12A4, J1_SETUP, 0, 0, 0, 1, 0, WIN_NONE, 0, 0, 0));
        vt.push_back(mk(1, 0, 16'h0000, J1_SETUP, 0, 0, 0, 0, 0, WIN_NONE, 0, 0, 0));
        vt.push_back(mk(1, 1, 16'h1234, J2_SETUP, 0, 0, 0, 0, 0, WIN_NONE, 0, 0, 0));
        vt.push_back(mk(1, 1, 16'h5678, J1_GUESS, 0, 0, 0, 0, 0, WIN_NONE, 0, 0, 0));
        vt.push_back(mk(1, 1, 16'h1123, J1_GUESS, 0, 0, 0, 1, 0, WIN_NONE, 0, 0, 0));
        vt.push_back(mk(1, 1, 16'h12A4, J1_GUESS, 0, 0, 0, 1, 0, WIN_NONE, 0, 0, 0));
        vt.push_back(mk(1, 1, 16'h5687, J2_GUESS, 2, 2, 1, 0, 0, WIN_NONE, 0, 0, 0));
        vt.push_back(mk(1, 0, 16'h0000, J2_GUESS, 2, 2, 0, 0, 0, WIN_NONE, 0, 0, 0));
        vt.push_back(mk(1, 1, 16'h1234, END_GAME, 4, 0, 1, 0, 1, WIN_J2,   0, 1, 0));
        vt.push_back(mk(1, 0, 16'h0000, END_GAME, 4, 0, 0, 0, 1, WIN_J2,   0, 1, 0));
        vt.push_back(mk(1, 1, 16'h1123, J1_SETUP, 0, 0, 0, 0, 0, WIN_NONE, 0, 1, 0));
        // draw game: no guess shares a digit with either secret
        vt.push_back(mk(1, 1, 16'h1234, J2_SETUP, 0, 0, 0, 0, 0, WIN_NONE, 0, 1, 0));
        vt.push_back(mk(1, 1, 16'h4321, J1_GUESS, 0, 0, 0, 0, 0, WIN_NONE, 0, 1, 0));
        vt.push_back(mk(1, 1, 16'h9870, J2_GUESS, 0, 0, 1, 0, 0, WIN_NONE, 0, 1, 0));
        vt.push_back(mk(1, 1, 16'h9870, J1_GUESS, 0, 0, 1, 0, 0, WIN_NONE, 0, 1, 1));
        vt.push_back(mk(1, 1, 16'h9870, J2_GUESS, 0, 0, 1, 0, 0, WIN_NONE, 0, 1, 1));
        vt.push_back(mk(1, 1, 16'h9870, END_GAME, 0, 0, 1, 0, 1, WIN_DRAW, 0, 1, 2));
        vt.push_back(mk(1, 1, 16'h9870, J1_SETUP, 0, 0, 0, 0, 0, WIN_NONE, 0, 1, 0));

        @(negedge clock);
        foreach (vt[i]) apply($sformatf("v%0d", i), vt[i]);

        // Four straight J1 wins: score saturates at 3 with SCORE_W=2.
        for (int g = 0; g < 4; g++) begin
            int e1;
            e1 = (g + 1 > 3) ? 3 : g + 1;
            apply($sformatf("sat%0d.s1", g), mk(1, 1, 16'h1234, J2_SETUP, 0, 0, 0, 0, 0, WIN_NONE, g, 1, 0));
            apply($sformatf("sat%0d.s2", g), mk(1, 1, 16'h5678, J1_GUESS, 0, 0, 0, 0, 0, WIN_NONE, g, 1, 0));
            apply($sformatf("sat%0d.win", g), mk(1, 1, 16'h5678, END_GAME, 4, 0, 1, 0, 1, WIN_J1, e1, 1, 0));
            apply($sformatf("sat%0d.next", g), mk(1, 1, 16'h0000, J1_SETUP, 0, 0, 0, 0, 0, WIN_NONE, e1, 1, 0));
        end

        // Reset in the middle of a game, with enter held high.
        apply("mid.s1",  mk(1, 1, 16'h1234, J2_SETUP, 0, 0, 0, 0, 0, WIN_NONE, 3, 1, 0));
        apply("mid.s2",  mk(1, 1, 16'h5678, J1_GUESS, 0, 0, 0, 0, 0, WIN_NONE, 3, 1, 0));
        apply("mid.g1",  mk(1, 1, 16'h9870, J2_GUESS, 1, 1, 1, 0, 0, WIN_NONE, 3, 1, 0));
        apply("mid.rst", mk(0, 1, 16'h1234, J1_SETUP, 0, 0, 0, 0, 0, WIN_NONE, 0, 0, 0));
        apply("mid.rs2", mk(0, 1, 16'h1234, J1_SETUP, 0, 0, 0, 0, 0, WIN_NONE, 0, 0, 0));
        apply("mid.rel", mk(1, 0, 16'h1234, J1_SETUP, 0, 0, 0, 0, 0, WIN_NONE, 0, 0, 0));
        apply("mid.go",  mk(1, 1, 16'h1234, J2_SETUP, 0, 0, 0, 0, 0, WIN_NONE, 0, 0, 0));
        enter = 1'b0;

        // 6-digit game.
        apply6("d6.dup",   24'h012340, J1_SETUP, 0, 0, 0, 1, 0);
        apply6("d6.s1",    24'h012345, J2_SETUP, 0, 0, 0, 0, 0);
        apply6("d6.s2",    24'h012345, J1_GUESS, 0, 0, 0, 0, 0);
        apply6("d6.g1",    24'h015432, J2_GUESS, 2, 4, 1, 0, 0);
        apply6("d6.g2",    24'h012534, J1_GUESS, 3, 3, 1, 0, 1);
        enter6 = 1'b0;
        @(negedge clock);
        chk("d6.hold.rv", 32'(rv6), 32'd0);
        chk("d6.hold.go", 32'(go6), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
